fizzbuzz_ascii_tx: RTL and testbench

- Downstream consumer of the FizzBuzz flag generator.
- Accepts one token per counter step: the fizz, buzz and fizzbuzz flags plus the step index.
- Serialises each token into an ASCII byte stream over a valid/ready interface: "Fizz", "Buzz", "FizzBuzz" or the decimal index, each followed by a newline.
- Feeds the UART/console stage of the demo design.

---
 rtl/fizzbuzz_ascii_tx.sv | 169 ++++++++++++++++
 tb/tb_fizzbuzz_ascii_tx.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/fizzbuzz_ascii_tx.sv
// Serialises FizzBuzz tokens into ASCII bytes ("Fizz", "Buzz", "FizzBuzz" or decimal index),
// each terminated by a newline, over a valid/ready byte stream.
module fizzbuzz_ascii_tx #(
  parameter int unsigned IDX_W = 7
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_fizz,
  input  logic             in_buzz,
  input  logic             in_fizzbuzz,
  input  logic [IDX_W-1:0] in_index,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [7:0]       out_data,
  output logic             out_last
);

  typedef enum logic {S_IDLE, S_EMIT} state_t;
  typedef enum logic [1:0] {K_FIZZBUZZ, K_FIZZ, K_BUZZ, K_NUM} kind_t;

  state_t          r_state;
  kind_t           r_kind;
  logic [3:0][7:0] r_dig;
  logic [3:0]      r_len;
  logic [3:0]      r_ptr;
  logic            r_out_valid;
  logic [7:0]      r_out_data;
  logic            r_out_last;

  kind_t           w_kind;
  logic [3:0][7:0] w_dig;
  logic [3:0]      w_num_len;
  logic [3:0]      w_len;
  logic [13:0]     w_val;
  logic [3:0]      w_d3, w_d2, w_d1, w_d0;
  logic [7:0]      w_first;
  logic [7:0]      w_next;
  logic [3:0]      w_ptr_inc;

  function automatic logic [7:0] f_fizz(input logic [1:0] i);
    logic [7:0] c;
    unique case (i)
      2'd0:    c = 8'h46;
      2'd1:    c = 8'h69;
      default: c = 8'h7A;
    endcase
    return c;
  endfunction

  function automatic logic [7:0] f_buzz(input logic [1:0] i);
    logic [7:0] c;
    unique case (i)
      2'd0:    c = 8'h42;
      2'd1:    c = 8'h75;
      default: c = 8'h7A;
    endcase
    return c;
  endfunction

  // Byte at position idx of a token; position len is always the terminating newline.
  function automatic logic [7:0] f_byte(input kind_t k, input logic [3:0][7:0] dig,
                                        input logic [3:0] len, input logic [3:0] idx);
    logic [7:0] c;
    if (idx == len) begin
      c = 8'h0A;
    end else begin
      unique case (k)
        K_FIZZBUZZ: c = idx[2] ? f_buzz(idx[1:0]) : f_fizz(idx[1:0]);
        K_FIZZ:     c = f_fizz(idx[1:0]);
        K_BUZZ:     c = f_buzz(idx[1:0]);
        default:    c = dig[idx[1:0]];
      endcase
    end
    return c;
  endfunction

  always_comb begin
    w_val = 14'(in_index);
    w_d0  = 4'(w_val % 14'd10);
    w_d1  = 4'((w_val / 14'd10) % 14'd10);
    w_d2  = 4'((w_val / 14'd100) % 14'd10);
    w_d3  = 4'(w_val / 14'd1000);

    // Digits are left-aligned so entry 0 is always the most significant one.
    w_dig     = '0;
    w_num_len = 4'd1;
    if (w_val >= 14'd1000) begin
      w_num_len = 4'd4;
      w_dig     = {{4'h3, w_d0}, {4'h3, w_d1}, {4'h3, w_d2}, {4'h3, w_d3}};
    end else if (w_val >= 14'd100) begin
      w_num_len = 4'd3;
      w_dig     = {8'h00, {4'h3, w_d0}, {4'h3, w_d1}, {4'h3, w_d2}};
    end else if (w_val >= 14'd10) begin
      w_num_len = 4'd2;
      w_dig     = {16'h0000, {4'h3, w_d0}, {4'h3, w_d1}};
    end else begin
      w_dig     = {24'h000000, {4'h3, w_d0}};
    end

    if (in_fizzbuzz || (in_fizz && in_buzz)) begin
      w_kind = K_FIZZBUZZ;
      w_len  = 4'd8;
    end else if (in_fizz) begin
      w_kind = K_FIZZ;
      w_len  = 4'd4;
    end else if (in_buzz) begin
      w_kind = K_BUZZ;
      w_len  = 4'd4;
    end else begin
      w_kind = K_NUM;
      w_len  = w_num_len;
    end

    w_ptr_inc = r_ptr + 4'd1;
    w_first   = f_byte(w_kind, w_dig, w_len, 4'd0);
    w_next    = f_byte(r_kind, r_dig, r_len, w_ptr_inc);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state     <= S_IDLE;
      r_kind      <= K_NUM;
      r_dig       <= '0;
      r_len       <= '0;
      r_ptr       <= '0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_last  <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_kind      <= w_kind;
            r_dig       <= w_dig;
            r_len       <= w_len;
            r_ptr       <= '0;
            r_out_valid <= 1'b1;
            r_out_data  <= w_first;
            r_out_last  <= 1'b0;
            r_state     <= S_EMIT;
          end
        end
        S_EMIT: begin
          if (out_ready) begin
            if (r_out_last) begin
              r_out_valid <= 1'b0;
              r_out_last  <= 1'b0;
              r_ptr       <= '0;
              r_state     <= S_IDLE;
            end else begin
              r_ptr      <= w_ptr_inc;
              r_out_data <= w_next;
              r_out_last <= (w_ptr_inc == r_len);
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign in_ready  = (r_state == S_IDLE);
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_last  = r_out_last;

endmodule

// File: tb/tb_fizzbuzz_ascii_tx.sv
// Bench for fizzbuzz_ascii_tx: directed cases plus randomized tokens and sink stalls,
// checked against a string-level reference model.
module tb_fizzbuzz_ascii_tx;

  localparam int unsigned IDX_W = 7;

  logic             clk = 1'b0;
  logic             resetn;
  logic             in_valid;
  logic             in_ready;
  logic             in_fizz;
  logic             in_buzz;
  logic             in_fizzbuzz;
  logic [IDX_W-1:0] in_index;
  logic             out_valid;
  logic             out_ready;
  logic [7:0]       out_data;
  logic             out_last;

  int n_checks = 0;
  int n_errors = 0;

  fizzbuzz_ascii_tx #(.IDX_W(IDX_W)) dut (
    .clk        (clk),
    .resetn     (resetn),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_fizz    (in_fizz),
    .in_buzz    (in_buzz),
    .in_fizzbuzz(in_fizzbuzz),
    .in_index   (in_index),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_last   (out_last)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference: the token text from the flag priority rules, decimal via string formatting.
  function automatic string model_text(input logic f, input logic b, input logic fb,
                                       input int unsigned idx);
    if (fb || (f && b)) return "FizzBuzz";
    if (f)              return "Fizz";
    if (b)              return "Buzz";
    return $sformatf("%0d", idx);
  endfunction

  task automatic wait_idle();
    int guard = 0;
    while (!in_ready && guard < 50) begin
      @(posedge clk); #1;
      guard++;
    end
    check_eq("wait_in_ready", {31'd0, in_ready}, 32'd1);
  endtask

  task automatic accept_token(input logic f, input logic b, input logic fb,
                              input int unsigned idx);
    wait_idle();
    in_valid    = 1'b1;
    in_fizz     = f;
    in_buzz     = b;
    in_fizzbuzz = fb;
    in_index    = IDX_W'(idx);
    @(posedge clk); #1;
    in_valid    = 1'b0;
    // Scramble inputs while emitting; the captured token must be unaffected.
    in_fizz     = 1'($urandom);
    in_buzz     = 1'($urandom);
    in_fizzbuzz = 1'($urandom);
    in_index    = IDX_W'($urandom);
    check_eq("lat1_out_valid", {31'd0, out_valid}, 32'd1);
    check_eq("emit_in_ready", {31'd0, in_ready}, 32'd0);
  endtask

  // mode 0: out_ready always high; 1: random; 2: pattern 1,0,0,1,1 repeating.
  task automatic drain_token(input string text, input int mode);
    byte exp_q[$];
    int  i = 0;
    int  cyc = 0;
    logic       rdy;
    logic [7:0] d;
    logic       l;
    logic       v;
    logic [4:0] pat = 5'b11001;
    for (int k = 0; k < text.len(); k++) exp_q.push_back(text[k]);
    exp_q.push_back(8'h0A);
    while (i < exp_q.size() && cyc < 300) begin
      case (mode)
        0:       rdy = 1'b1;
        1:       rdy = 1'($urandom_range(0, 1));
        default: rdy = pat[cyc % 5];
      endcase
      out_ready = rdy;
      d = out_data;
      l = out_last;
      v = out_valid;
      @(posedge clk); #1;
      cyc++;
      if (v && rdy) begin
        check_eq("byte", {24'd0, d}, {24'd0, exp_q[i]});
        check_eq("last", {31'd0, l}, {31'd0, (i == exp_q.size() - 1)});
        i++;
      end else begin
        check_eq("stall_valid", {31'd0, out_valid}, 32'd1);
        check_eq("stall_data", {24'd0, out_data}, {24'd0, d});
        check_eq("stall_last", {31'd0, out_last}, {31'd0, l});
      end
    end
    check_eq("drain_timeout", {31'd0, (cyc >= 300)}, 32'd0);
    check_eq("post_in_ready", {31'd0, in_ready}, 32'd1);
    check_eq("post_out_valid", {31'd0, out_valid}, 32'd0);
    out_ready = 1'b1;
  endtask

  task automatic run_token(input logic f, input logic b, input logic fb,
                           input int unsigned idx, input int mode);
    accept_token(f, b, fb, idx);
    drain_token(model_text(f, b, fb, idx), mode);
  endtask

  initial begin
    resetn      = 1'b0;
    in_valid    = 1'b0;
    in_fizz     = 1'b0;
    in_buzz     = 1'b0;
    in_fizzbuzz = 1'b0;
    in_index    = '0;
    out_ready   = 1'b1;
    #23;
    check_eq("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check_eq("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check_eq("rst_out_data", {24'd0, out_data}, 32'd0);
    check_eq("rst_out_last", {31'd0, out_last}, 32'd0);
    resetn = 1'b1;
    @(posedge clk); #1;

    run_token(1'b0, 1'b0, 1'b0, 1, 0);
    run_token(1'b1, 1'b0, 1'b0, 3, 0);
    run_token(1'b1, 1'b1, 1'b1, 0, 0);
    run_token(1'b1, 1'b1, 1'b0, 0, 0);
    run_token(1'b0, 1'b0, 1'b0, 0, 0);
    run_token(1'b0, 1'b0, 1'b0, 98, 2);
    run_token(1'b0, 1'b0, 1'b0, 100, 1);
    run_token(1'b0, 1'b0, 1'b0, 127, 2);
    run_token(1'b0, 1'b1, 1'b0, 5, 1);

    // Asynchronous reset in the middle of "Buzz", after 42 and 75 have transferred.
    accept_token(1'b0, 1'b1, 1'b0, 10);
    out_ready = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #2;
    check_eq("mid_data", {24'd0, out_data}, 32'h7A);
    resetn = 1'b0;
    #1;
    check_eq("async_out_valid", {31'd0, out_valid}, 32'd0);
    check_eq("async_in_ready", {31'd0, in_ready}, 32'd1);
    check_eq("async_out_data", {24'd0, out_data}, 32'd0);
    #4;
    resetn = 1'b1;
    @(posedge clk); #1;
    check_eq("post_rst_idle", {31'd0, out_valid}, 32'd0);
    run_token(1'b0, 1'b0, 1'b0, 7, 0);

    for (int t = 0; t < 40; t++) begin
      run_token(1'($urandom), 1'($urandom), 1'($urandom_range(0, 3) == 0),
                $urandom_range(0, (1 << IDX_W) - 1), $urandom_range(0, 2));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
